// File: rtl/ucore_axi_rd_arb.sv
// ucore_axi_rd_arb: two-requester, round-robin arbiter issuing single-word
// AXI4 reads with at most one read outstanding.
// Optional build macro UCORE_ARB_TIMEOUT_EN adds an R-phase watchdog
// (parameter TIMEOUT) and a DRAIN state that absorbs a late beat.
module ucore_axi_rd_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        aresetn,
    // requester side
    input  logic        req0_valid,
    input  logic [27:0] req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [27:0] req1_addr,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    // AXI read address channel
    output logic [27:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    output logic [3:0]  m_axi_arid,
    input  logic        m_axi_arready,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arlock,
    output logic [3:0]  m_axi_arqos,
    // AXI read data channel
    input  logic [31:0] m_axi_rdata,
    input  logic [3:0]  m_axi_rid,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

`ifdef UCORE_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AR    = 2'd1,
        S_R     = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // watchdog is at least 8 bits wide, wider if TIMEOUT needs it
    localparam int TW_RAW = $clog2(TIMEOUT + 1);
    localparam int TW     = (TW_RAW > 8) ? TW_RAW : 8;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_pri;          // 0: requester 0 wins a tie, 1: requester 1 wins
    logic [27:0] r_araddr;
    logic [3:0]  r_arid;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_grant;
    logic        w_issue;
    logic        w_r_hs;
    logic        w_beat_err;
    logic        w_timeout;

`ifdef UCORE_ARB_TIMEOUT_EN
    logic [TW-1:0] r_tcnt;
`endif

    // rresp[0] only distinguishes OKAY/EXOKAY, which both count as success
    logic w_unused_ok;
    assign w_unused_ok = ^{m_axi_rresp[0], 1'(TIMEOUT)};

    // round-robin pick between the two requesters
    always_comb begin
        w_gnt0  = req0_valid && (!req1_valid || !r_pri);
        w_gnt1  = req1_valid && (!req0_valid ||  r_pri);
        w_grant = w_gnt0 || w_gnt1;
    end

    // a beat is in error on SLVERR/DECERR, an id mismatch or a missing rlast
    assign w_beat_err = m_axi_rresp[1] || (m_axi_rid != r_arid) || !m_axi_rlast;

    // next-state logic and combinational handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_r_hs        = 1'b0;
        w_timeout     = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_gnt0;
                req1_ready = w_gnt1;
                if (w_grant) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_AR;
                end
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready)
                    w_state_nxt = S_R;
            end
            S_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    w_r_hs      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`ifdef UCORE_ARB_TIMEOUT_EN
                // counter holds the number of R cycles already spent, so this
                // fires in the TIMEOUT-th R cycle
                else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
`endif
            end
`ifdef UCORE_ARB_TIMEOUT_EN
            S_DRAIN: begin
                // swallow the late beat; no grants until it is gone
                m_axi_rready = 1'b1;
                if (m_axi_rvalid)
                    w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // latch the granted request and advance the round-robin pointer
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_araddr <= '0;
            r_arid   <= '0;
            r_pri    <= 1'b0;
        end else if (w_issue) begin
            r_araddr <= w_gnt1 ? req1_addr : req0_addr;
            r_arid   <= {3'b000, w_gnt1};
            r_pri    <= !w_gnt1;
        end
    end

    // one-cycle response pulse to whichever requester owns the outstanding read
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            if (w_r_hs) begin
                r_rsp0_valid <= !r_arid[0];
                r_rsp1_valid <=  r_arid[0];
                r_rsp_data   <= m_axi_rdata;
                r_rsp_err    <= w_beat_err;
            end else if (w_timeout) begin
                r_rsp0_valid <= !r_arid[0];
                r_rsp1_valid <=  r_arid[0];
                r_rsp_data   <= '0;
                r_rsp_err    <= 1'b1;
            end
        end
    end

`ifdef UCORE_ARB_TIMEOUT_EN
    // watchdog: counts cycles spent waiting in R, cleared everywhere else
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            r_tcnt <= '0;
        else if (r_state == S_R)
            r_tcnt <= r_tcnt + 1'b1;
        else
            r_tcnt <= '0;
    end
`endif

    assign rsp0_valid    = r_rsp0_valid;
    assign rsp1_valid    = r_rsp1_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_rsp_err;

    assign m_axi_araddr  = r_araddr;
    assign m_axi_arid    = r_arid;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arqos   = 4'd0;

endmodule

// File: tb/tb_ucore_axi_rd_arb.sv
// Bench for ucore_axi_rd_arb: requester/AXI-slave driver, scoreboard monitor.
// Timeout/drain scenario is compiled in when UCORE_ARB_TIMEOUT_EN is defined.
module tb_ucore_axi_rd_arb;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [27:0] req0_addr = '0, req1_addr = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [27:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic [3:0]  m_axi_arid;
    logic        m_axi_arready = 1'b0;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arqos;
    logic [31:0] m_axi_rdata = '0;
    logic [3:0]  m_axi_rid = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    always #5 clk = ~clk;

    ucore_axi_rd_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .aresetn(aresetn),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arid(m_axi_arid), .m_axi_arready(m_axi_arready),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arlock(m_axi_arlock),
        .m_axi_arqos(m_axi_arqos),
        .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    typedef struct packed { logic idx; logic [27:0] addr; } ar_exp_t;
    typedef struct packed { logic idx; logic [31:0] data; logic err; } rsp_exp_t;

    ar_exp_t  ar_q[$];
    rsp_exp_t rsp_q[$];
    int       ar_cyc_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int ar_hs_cnt = 0, ar_run = 0, last_ar_run = 0, last_rsp_cyc = 0;

    // slave / requester configuration (main process only)
    int          cfg_ardly = 0, cfg_rdly = 0;
    logic        cfg_fixed = 1'b0, cfg_bad_rid = 1'b0, cfg_nolast = 1'b0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0;
    int          posted0 = 0, posted1 = 0;
    logic [27:0] base0 = 28'h0000100, base1 = 28'h0002000;

    // driver-owned state
    int          done0 = 0, done1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [27:0] addr_of(input logic [27:0] base, input int n);
        return base + 28'(n) * 28'd16;
    endfunction

    function automatic logic [31:0] data_of(input logic [27:0] a);
        return {4'h5, a};
    endfunction

    task automatic expect_txn(input logic idx, input logic [27:0] a,
                              input logic [31:0] d, input logic e);
        ar_q.push_back('{idx: idx, addr: a});
        rsp_q.push_back('{idx: idx, data: d, err: e});
    endtask

    task automatic wait_done(input int max);
        int i;
        for (i = 0; i < max && (rsp_q.size() != 0 || ar_q.size() != 0); i++)
            @(negedge clk);
        chk("wait_done", rsp_q.size() + ar_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // requesters and AXI slave: sample at negedge, drive 1 time unit after posedge
    initial begin
        logic ar_hs, r_hs, h0, h1;
        logic [27:0] s_addr;
        logic [3:0]  s_id;
        logic        s_pend;
        int          arcnt, rcnt;
        s_pend = 1'b0; arcnt = 0; rcnt = 0; s_addr = '0; s_id = '0;
        forever begin
            @(negedge clk);
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            h0    = req0_valid && req0_ready && aresetn;
            h1    = req1_valid && req1_ready && aresetn;
            if (ar_hs) begin s_addr = m_axi_araddr; s_id = m_axi_arid; end
            @(posedge clk);
            #1;
            if (!aresetn) begin
                s_pend = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; arcnt = cfg_ardly;
            end else begin
                if (h0) done0++;
                if (h1) done1++;
                if (r_hs) begin m_axi_rvalid = 1'b0; s_pend = 1'b0; end
                if (ar_hs || !m_axi_arvalid) begin
                    m_axi_arready = 1'b0; arcnt = cfg_ardly;
                end else if (arcnt == 0) m_axi_arready = 1'b1;
                else arcnt--;
                if (ar_hs) begin s_pend = 1'b1; rcnt = cfg_rdly; end
                if (s_pend && !m_axi_rvalid) begin
                    if (rcnt == 0) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = cfg_fixed ? cfg_rdata : data_of(s_addr);
                        m_axi_rid    = cfg_bad_rid ? 4'd3 : s_id;
                        m_axi_rresp  = cfg_rresp;
                        m_axi_rlast  = !cfg_nolast;
                    end else rcnt--;
                end
            end
            req0_valid = (posted0 != done0);
            req1_valid = (posted1 != done1);
            req0_addr  = addr_of(base0, done0);
            req1_addr  = addr_of(base1, done1);
        end
    end

    // monitor / scoreboard
    initial begin
        logic        prev_arv;
        logic [27:0] prev_addr;
        ar_exp_t     ea;
        rsp_exp_t    er;
        prev_arv = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (aresetn) begin
                if (rsp0_valid || rsp1_valid) begin
                    last_rsp_cyc = cyc;
                    chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 0);
                    if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                    else begin
                        er = rsp_q.pop_front();
                        chk("rsp_idx", 32'(rsp1_valid), 32'(er.idx));
                        chk("rsp_data", rsp_data, er.data);
                        chk("rsp_err", 32'(rsp_err), 32'(er.err));
                    end
                end
                if (m_axi_arvalid) begin
                    if (prev_arv) chk("ar_stable", 32'(m_axi_araddr), 32'(prev_addr));
                    ar_run++;
                end else ar_run = 0;
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_hs_cnt++;
                    last_ar_run = ar_run;
                    ar_cyc_q.push_back(cyc);
                    if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
                    else begin
                        ea = ar_q.pop_front();
                        chk("araddr", 32'(m_axi_araddr), 32'(ea.addr));
                        chk("arid", 32'(m_axi_arid), 32'(ea.idx));
                    end
                end
                prev_arv  = m_axi_arvalid;
                prev_addr = m_axi_araddr;
            end else prev_arv = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // main sequence
    initial begin
        int hs_before;
        logic [27:0] a;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_arvalid", 32'(m_axi_arvalid), 0);
        chk("rst_rready", 32'(m_axi_rready), 0);
        chk("rst_rsp0", 32'(rsp0_valid), 0);
        chk("rst_rsp1", 32'(rsp1_valid), 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_araddr", 32'(m_axi_araddr), 0);
        chk("rst_arid", 32'(m_axi_arid), 0);
        chk("arlen", 32'(m_axi_arlen), 0);
        chk("arsize", 32'(m_axi_arsize), 2);
        chk("arburst", 32'(m_axi_arburst), 1);
        chk("arcache", 32'(m_axi_arcache), 3);
        chk("arprot_lock_qos", {m_axi_arprot, m_axi_arlock, m_axi_arqos}, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);

        // single req0 read, fixed data
        cfg_fixed = 1'b1; cfg_rdata = 32'hDEADBEEF;
        expect_txn(1'b0, 28'h0000100, 32'hDEADBEEF, 1'b0);
        posted0++;
        wait_done(40);
        cfg_fixed = 1'b0;

        // req1 read with SLVERR (also leaves the pointer favouring requester 0)
        cfg_rresp = 2'b10;
        a = addr_of(base1, done1);
        expect_txn(1'b1, a, data_of(a), 1'b1);
        posted1++;
        wait_done(40);
        cfg_rresp = 2'b00;

        // both held for four transactions: 0,1,0,1 at 3-cycle spacing
        ar_cyc_q.delete();
        a = addr_of(base0, done0);     expect_txn(1'b0, a, data_of(a), 1'b0);
        a = addr_of(base1, done1);     expect_txn(1'b1, a, data_of(a), 1'b0);
        a = addr_of(base0, done0 + 1); expect_txn(1'b0, a, data_of(a), 1'b0);
        a = addr_of(base1, done1 + 1); expect_txn(1'b1, a, data_of(a), 1'b0);
        posted0 += 2; posted1 += 2;
        wait_done(80);
        chk("rr_count", ar_cyc_q.size(), 4);
        for (int i = 0; i + 1 < ar_cyc_q.size(); i++)
            chk("issue_gap", ar_cyc_q[i+1] - ar_cyc_q[i], 3);

        // wrong rid
        cfg_bad_rid = 1'b1;
        a = addr_of(base0, done0);
        expect_txn(1'b0, a, data_of(a), 1'b1);
        posted0++;
        wait_done(40);
        cfg_bad_rid = 1'b0;

        // missing rlast
        cfg_nolast = 1'b1;
        a = addr_of(base1, done1);
        expect_txn(1'b1, a, data_of(a), 1'b1);
        posted1++;
        wait_done(40);
        cfg_nolast = 1'b0;

        // arready delayed 5 cycles
        cfg_ardly = 5;
        hs_before = ar_hs_cnt;
        a = addr_of(base0, done0);
        expect_txn(1'b0, a, data_of(a), 1'b0);
        posted0++;
        wait_done(60);
        chk("ar_hold_len", last_ar_run, 6);
        chk("ar_hs_once", ar_hs_cnt - hs_before, 1);
        cfg_ardly = 0;

        // reset in R abandons the read
        cfg_rdly = 10;
        a = addr_of(base0, done0);
        ar_q.push_back('{idx: 1'b0, addr: a});
        posted0++;
        for (int i = 0; i < 20 && !m_axi_rready; i++) @(negedge clk);
        chk("reach_r", 32'(m_axi_rready), 1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_arvalid", 32'(m_axi_arvalid), 0);
        chk("mid_rst_rready", 32'(m_axi_rready), 0);
        chk("mid_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        cfg_rdly = 0;
        repeat (15) @(negedge clk);
        chk("post_rst_queue", ar_q.size() + rsp_q.size(), 0);
        a = addr_of(base0, done0);
        expect_txn(1'b0, a, data_of(a), 1'b0);
        posted0++;
        wait_done(40);

`ifdef UCORE_ARB_TIMEOUT_EN
        // withheld beat: error pulse follows the 16th R cycle, late beat drained
        cfg_rdly = 20;
        ar_cyc_q.delete();
        a = addr_of(base0, done0);
        expect_txn(1'b0, a, 32'h0, 1'b1);
        posted0++;
        for (int i = 0; i < 60 && rsp_q.size() != 0; i++) @(negedge clk);
        chk("to_rsp_seen", rsp_q.size(), 0);
        chk("to_latency", last_rsp_cyc - ar_cyc_q[0], TO + 1);
        cfg_rdly = 0;
        hs_before = ar_hs_cnt;
        a = addr_of(base1, done1);
        expect_txn(1'b1, a, data_of(a), 1'b0);
        posted1++;
        repeat (2) @(negedge clk);
        chk("drain_no_grant", ar_hs_cnt - hs_before, 0);
        wait_done(40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ucore_axi_rd_arb.md
UCORE_AXI_RD_ARB -- requirements
Module: ucore_axi_rd_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning R-phase watchdog limit in clk cycles (used only with UCORE_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port aresetn, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1, meaning requester N wants a single-word read.
REQ-005 SHALL have ports req0_addr / req1_addr, input, 28, meaning the byte address for requester N.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1, meaning the request is accepted this cycle.
REQ-007 SHALL have ports rsp0_valid / rsp1_valid, output, 1, meaning a one-cycle response pulse to requester N.
REQ-008 SHALL have port rsp_data, output, 32, meaning read data, shared by both requesters, valid with rspN_valid.
REQ-009 SHALL have port rsp_err, output, 1, meaning error, valid with rspN_valid.
REQ-010 SHALL have AXI read-address outputs m_axi_araddr (28), m_axi_arvalid (1), m_axi_arid (4), and input m_axi_arready (1).
REQ-011 SHALL have constant AXI outputs: arlen=0 (8), arsize=3'b010, arburst=2'b01, arcache=4'b0011, arprot=3'b000, arlock=0, arqos=0.
REQ-012 SHALL have AXI read-data inputs m_axi_rdata (32), m_axi_rid (4), m_axi_rresp (2), m_axi_rlast (1), m_axi_rvalid (1), and output m_axi_rready (1).

Function
REQ-013 SHALL implement the FSM states IDLE, AR, R (plus DRAIN when UCORE_ARB_TIMEOUT_EN is defined), with at most one read outstanding.
REQ-014 In IDLE, if either reqN_valid is high, SHALL grant exactly one requester and assert its reqN_ready combinationally in that cycle.
REQ-015 In IDLE, SHALL register the granted address into m_axi_araddr and the grant index into m_axi_arid (0 or 1), then enter AR.
REQ-016 Arbitration SHALL be round-robin: when both request, grant the one not granted last; the pointer resets to favour requester 0.
REQ-017 In AR, SHALL hold m_axi_arvalid=1 with stable araddr/arid until m_axi_arready=1; on that handshake, SHALL enter R with arvalid=0 in the next cycle.
REQ-018 In R, SHALL hold m_axi_rready=1; on m_axi_rvalid=1, SHALL capture rdata and enter IDLE.
REQ-019 One cycle after the R handshake, SHALL pulse rspN_valid for the granted N, with rsp_data=captured rdata.
REQ-020 rsp_err SHALL be 1 if rresp[1]=1, or if rid does not equal the issued arid, or if rlast=0; otherwise 0.
REQ-021 reqN_ready SHALL be 0 in every state except IDLE, and m_axi_rready SHALL be 0 outside R/DRAIN.
REQ-022 A new grant SHALL be possible in the same cycle as a rsp pulse; minimum issue-to-issue spacing is 3 cycles with zero-wait AXI.
REQ-023 Requests deasserted before grant SHALL be ignored without side effects; requesters hold reqN_valid/addr until reqN_ready.

Reset
REQ-024 On aresetn=0, SHALL immediately force state=IDLE, m_axi_arvalid=0, m_axi_rready=0, rsp0_valid=rsp1_valid=0, rsp_data=0, rsp_err=0, araddr=0, arid=0, and RR pointer=favour 0.
REQ-025 Reset asserted mid-transaction SHALL abandon it with no response pulse, and operation SHALL resume normally after deassertion.

Configuration
REQ-026 Macro UCORE_ARB_TIMEOUT_EN: when defined, an 8+ bit counter SHALL run in R; if it reaches TIMEOUT without rvalid, SHALL pulse rspN_valid with rsp_err=1 and rsp_data=0, then enter DRAIN.
REQ-027 In DRAIN (macro defined), SHALL hold rready=1, discard the next beat, then go to IDLE; no grants SHALL be made in DRAIN.
REQ-028 When the macro is undefined, SHALL have no counter and no DRAIN state, and R SHALL wait for rvalid indefinitely.

Verification
REQ-029 Only req0 with addr 0x0000100, arready and rvalid after one cycle, rdata=0xDEADBEEF, rresp=0 -> arid=0, araddr=0x0000100, rsp0_valid pulse, rsp_data=0xDEADBEEF, rsp_err=0.
REQ-030 req0 and req1 held continuously for 4 transactions -> grants in the order 0,1,0,1, with arid matching each grant.
REQ-031 rresp=2'b10 on req1 read -> rsp1_valid=1 with rsp_err=1; a wrong rid (3) -> rsp_err=1.
REQ-032 arready delayed 5 cycles -> arvalid held high for 6 cycles with araddr stable, and exactly one AR handshake.
REQ-033 aresetn pulled low while in R -> arvalid=0, rready=0, and no rsp pulse; after release, a req0 read completes normally.
REQ-034 With UCORE_ARB_TIMEOUT_EN and TIMEOUT=16, rvalid withheld -> error response at cycle 16 of R; a late beat is drained, then the next request is granted.
